int_serve: RTL and testbench

- Consumer side of the per-line interrupt request cells: reads their latched requests, arbitrates priority, hands one interrupt number to the control unit, and clears the request it served.
- Maintains the in-service register and enforces priority nesting against it.
- Sits between the request-cell array and the microprogram control; all interrupt acceptance is sequenced here.

---
 rtl/int_serve_if.sv | 28 ++
 rtl/int_serve.sv | 101 ++++++++++
 tb/tb_int_serve.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_serve_if.sv
// Bundle between the interrupt server, the request-cell array and the control unit.
// master = control/request side driving requests and handshakes; slave = int_serve.
interface int_serve_if #(
    parameter int N  = 32,
    parameter int IW = 5
);
    logic [N-1:0]  rz;
    logic [N-1:0]  mask;
    logic          chk;
    logic          ack;
    logic          ret;
    logic          irq;
    logic          valid;
    logic [IW-1:0] num;
    logic [N-1:0]  clr;
    logic [N-1:0]  rp;
    logic          busy;

    modport master (
        output rz, mask, chk, ack, ret,
        input  irq, valid, num, clr, rp, busy
    );

    modport slave (
        input  rz, mask, chk, ack, ret,
        output irq, valid, num, clr, rp, busy
    );
endinterface

// File: rtl/int_serve.sv
// Interrupt server: arbitrates latched requests, offers one number, clears it, tracks in-service.
// Macro INT_SERVE_NEST_EN enables priority nesting; otherwise one interrupt in service at a time.
module int_serve #(
    parameter int N  = 32,
    parameter int IW = 5
) (
    input  logic        clk_sys,
    input  logic        clm,
    int_serve_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] num_q, num_d;
    logic [N-1:0]  rp_q, rp_d;
    logic          irq_q, irq_d;

    logic [N-1:0]  clr_vec;
    logic [N-1:0]  rp_vis;
    logic [N-1:0]  prio_window;
    logic [N-1:0]  eligible;
    logic [IW-1:0] lowest_idx;
    logic          any_elig;

    // The served bit is part of the in-service view already during CLEAR.
    assign clr_vec = (state_q == S_CLEAR) ? (N'(1) << num_q) : '0;
    assign rp_vis  = rp_q | clr_vec;

    for (genvar gi = 0; gi < N; gi++) begin : g_win
`ifdef INT_SERVE_NEST_EN
        assign prio_window[gi] = ~|rp_vis[gi:0];
`else
        assign prio_window[gi] = ~|rp_vis;
`endif
    end

    assign eligible = bus.rz & bus.mask & prio_window;
    assign any_elig = |eligible;

    always_comb begin
        lowest_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lowest_idx = IW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        irq_d   = any_elig;
        // ret acts on the in-service set as it stood before any CLEAR set.
        rp_d    = bus.ret ? (rp_q & (rp_q - N'(1))) : rp_q;
        case (state_q)
            S_IDLE: begin
                if (bus.chk && any_elig) begin
                    num_d   = lowest_idx;
                    state_d = S_OFFER;
                end
            end
            S_OFFER: begin
                if (bus.ack) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                rp_d    = rp_d | clr_vec;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge clm) begin
        if (clm) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            rp_q    <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            rp_q    <= rp_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.irq   = irq_q;
    assign bus.valid = (state_q == S_OFFER);
    assign bus.num   = num_q;
    assign bus.clr   = clr_vec;
    assign bus.rp    = rp_vis;
    assign bus.busy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_int_serve.sv
// Self-checking bench for int_serve: directed scenarios plus randomized serving
// against a behavioural model of eligibility and the in-service set.
module tb_int_serve;
    localparam int N  = 32;
    localparam int IW = 5;

    logic         clk_sys = 1'b0;
    logic         clm;
    int           total = 0;
    int           bad   = 0;
    int           clr_cycles = 0;
    logic [N-1:0] rp_m;

    int_serve_if #(.N(N), .IW(IW)) bus ();

    int_serve #(.N(N), .IW(IW)) dut (
        .clk_sys (clk_sys),
        .clm     (clm),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (bus.clr !== '0) clr_cycles++;
    end

    // ---------------- reference model ----------------
    function automatic logic [N-1:0] m_elig(input logic [N-1:0] rz, input logic [N-1:0] mk,
                                            input logic [N-1:0] rp);
        logic [N-1:0] e;
        e = '0;
        for (int i = 0; i < N; i++) begin
            bit ok;
            ok = rz[i] && mk[i];
`ifdef INT_SERVE_NEST_EN
            for (int j = 0; j <= i; j++) if (rp[j]) ok = 1'b0;
`else
            if (rp != '0) ok = 1'b0;
`endif
            e[i] = ok;
        end
        return e;
    endfunction

    function automatic int m_lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ret(input logic [N-1:0] v);
        int k;
        k = m_lowest(v);
        if (k >= 0) v[k] = 1'b0;
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic pulse_chk;
        bus.chk = 1'b1;
        tick();
        bus.chk = 1'b0;
    endtask

    task automatic pulse_ack;
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

    task automatic pulse_ret;
        bus.ret = 1'b1;
        tick();
        bus.ret = 1'b0;
        rp_m = m_ret(rp_m);
    endtask

    task automatic drain_rp;
        for (int i = 0; i < N && rp_m != '0; i++) pulse_ret();
        total++;
        if (bus.rp !== '0) begin
            bad++;
            $display("FAIL drain_rp: rp=%h want 0", bus.rp);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        clm = 1'b1;
        bus.rz = '0; bus.mask = '1; bus.chk = 0; bus.ack = 0; bus.ret = 0;
        #12;
        total++;
        if ({bus.irq, bus.valid, bus.num, bus.clr, bus.rp, bus.busy} !== '0) begin
            bad++;
            $display("FAIL reset_state: irq=%b valid=%b num=%0d clr=%h rp=%h busy=%b want all 0",
                     bus.irq, bus.valid, bus.num, bus.clr, bus.rp, bus.busy);
        end
        tick();
        clm = 1'b0;
        rp_m = '0;
        bus.rz = 32'h0000_0010;
        tick();
        pulse_chk();
        total++;
        if (bus.valid !== 1'b1 || bus.num !== 5'd4) begin
            bad++;
            $display("FAIL reset_pre_offer: valid=%b num=%0d want 1/4", bus.valid, bus.num);
        end
        clr_cycles = 0;
        #2;
        clm = 1'b1;
        #1;
        total++;
        if (bus.valid !== 1'b0 || bus.rp !== '0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_abort: valid=%b rp=%h busy=%b want 0/0/0", bus.valid, bus.rp, bus.busy);
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        tick();
        clm = 1'b0;
        bus.rz = '0;
        repeat (3) tick();
        total++;
        if (clr_cycles !== 0) begin
            bad++;
            $display("FAIL reset_no_clr: clr cycles=%0d want 0", clr_cycles);
        end
        $display("txn reset abort mid-offer done");
    endtask

    task automatic test_single;
        bus.rz = 32'h0000_0100; bus.mask = '1;
        pulse_chk();
        total++;
        if (bus.valid !== 1'b1 || bus.num !== 5'd8) begin
            bad++;
            $display("FAIL single_offer: valid=%b num=%0d want 1/8", bus.valid, bus.num);
        end
        clr_cycles = 0;
        pulse_ack();
        total++;
        if (bus.clr !== 32'h0000_0100 || bus.rp !== 32'h0000_0100 || bus.valid !== 1'b0) begin
            bad++;
            $display("FAIL single_clear: clr=%h rp=%h valid=%b want 100/100/0", bus.clr, bus.rp, bus.valid);
        end
        rp_m = 32'h0000_0100;
        bus.rz = '0;
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.clr !== '0 || clr_cycles !== 1) begin
            bad++;
            $display("FAIL single_after: busy=%b clr=%h clr_cycles=%0d want 0/0/1", bus.busy, bus.clr, clr_cycles);
        end
        $display("txn single num=%0d rp=%h", 8, bus.rp);
        drain_rp();
    endtask

    task automatic test_priority;
        bus.rz = 32'h8000_0014; bus.mask = '1;
        pulse_chk();
        total++;
        if (bus.num !== 5'd2 || bus.valid !== 1'b1) begin
            bad++;
            $display("FAIL prio_offer: num=%0d valid=%b want 2/1", bus.num, bus.valid);
        end
        pulse_ack();
        total++;
        if (bus.clr !== 32'h0000_0004) begin
            bad++;
            $display("FAIL prio_clr: clr=%h want 4", bus.clr);
        end
        rp_m = 32'h0000_0004;
        bus.rz = 32'h8000_0010;
        tick();
        pulse_chk();
        total++;
        if (bus.valid !== 1'b0 || bus.irq !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL prio_blocked: valid=%b irq=%b busy=%b want 0/0/0", bus.valid, bus.irq, bus.busy);
        end
        $display("txn priority served 2, lines 4/31 blocked");
        bus.rz = '0;
        drain_rp();
    endtask

    task automatic test_mask;
        bus.rz = 32'h0000_0003; bus.mask = 32'hFFFF_FFFE;
        pulse_chk();
        total++;
        if (bus.num !== 5'd1 || bus.valid !== 1'b1) begin
            bad++;
            $display("FAIL mask_offer: num=%0d valid=%b want 1/1", bus.num, bus.valid);
        end
        pulse_ack();
        total++;
        if (bus.clr !== 32'h0000_0002) begin
            bad++;
            $display("FAIL mask_clr: clr=%h want 2", bus.clr);
        end
        rp_m = 32'h0000_0002;
        bus.rz = '0; bus.mask = '1;
        tick();
        $display("txn mask served 1");
        drain_rp();
    endtask

    task automatic test_nesting;
        bus.rz = 32'h0000_0400; bus.mask = '1;
        pulse_chk();
        pulse_ack();
        rp_m = 32'h0000_0400;
        bus.rz = '0;
        tick();
        bus.rz = 32'h0000_0020;
        tick();
`ifdef INT_SERVE_NEST_EN
        total++;
        if (bus.irq !== 1'b1) begin
            bad++;
            $display("FAIL nest_irq: irq=%b want 1", bus.irq);
        end
        pulse_chk();
        total++;
        if (bus.valid !== 1'b1 || bus.num !== 5'd5) begin
            bad++;
            $display("FAIL nest_offer: valid=%b num=%0d want 1/5", bus.valid, bus.num);
        end
        pulse_ack();
        total++;
        if (bus.rp !== 32'h0000_0420) begin
            bad++;
            $display("FAIL nest_rp: rp=%h want 420", bus.rp);
        end
        rp_m = 32'h0000_0420;
        bus.rz = '0;
        tick();
        pulse_ret();
        total++;
        if (bus.rp !== 32'h0000_0400) begin
            bad++;
            $display("FAIL nest_ret: rp=%h want 400", bus.rp);
        end
`else
        total++;
        if (bus.irq !== 1'b0) begin
            bad++;
            $display("FAIL flat_irq: irq=%b want 0", bus.irq);
        end
        pulse_chk();
        total++;
        if (bus.valid !== 1'b0) begin
            bad++;
            $display("FAIL flat_no_offer: valid=%b want 0", bus.valid);
        end
        pulse_ret();
        total++;
        if (bus.rp !== '0) begin
            bad++;
            $display("FAIL flat_ret: rp=%h want 0", bus.rp);
        end
        pulse_chk();
        total++;
        if (bus.valid !== 1'b1 || bus.num !== 5'd5) begin
            bad++;
            $display("FAIL flat_offer: valid=%b num=%0d want 1/5", bus.valid, bus.num);
        end
        pulse_ack();
        rp_m = 32'h0000_0020;
        bus.rz = '0;
        tick();
`endif
        $display("txn nesting rp=%h", bus.rp);
        drain_rp();
    endtask

    task automatic test_corner;
        logic [N-1:0] want;
`ifdef INT_SERVE_NEST_EN
        bus.rz = 32'h0000_0010; bus.mask = '1;
        pulse_chk();
        pulse_ack();
        rp_m = 32'h0000_0010;
        bus.rz = '0;
        tick();
`endif
        bus.rz = 32'h0000_0008; bus.mask = '1;
        pulse_chk();
        total++;
        if (bus.num !== 5'd3 || bus.valid !== 1'b1) begin
            bad++;
            $display("FAIL corner_offer: num=%0d valid=%b want 3/1", bus.num, bus.valid);
        end
        pulse_ack();
        want = m_ret(rp_m) | 32'h0000_0008;
        bus.ret = 1'b1;
        tick();
        bus.ret = 1'b0;
        rp_m = want;
        total++;
        if (bus.rp !== want) begin
            bad++;
            $display("FAIL corner_ret_in_clear: rp=%h want %h", bus.rp, want);
        end
        $display("txn ret in clear rp=%h", bus.rp);
        bus.rz = '0;
        drain_rp();

        bus.rz = 32'h0000_0040;
        pulse_chk();
        bus.rz = '0;
        tick();
        total++;
        if (bus.valid !== 1'b1 || bus.num !== 5'd6) begin
            bad++;
            $display("FAIL drop_hold: valid=%b num=%0d want 1/6", bus.valid, bus.num);
        end
        pulse_ack();
        total++;
        if (bus.clr !== 32'h0000_0040) begin
            bad++;
            $display("FAIL drop_clr: clr=%h want 40", bus.clr);
        end
        rp_m = 32'h0000_0040;
        tick();
        $display("txn dropped request still cleared line 6");
        drain_rp();
    endtask

    task automatic test_random;
        logic [N-1:0] rz_v, mk_v, e, bitv;
        int k;
        for (int it = 0; it < 40; it++) begin
            rz_v = $urandom & $urandom & $urandom;
            mk_v = $urandom | $urandom;
            if (rp_m != '0 && $urandom_range(0, 1) == 1) pulse_ret();
            bus.rz = rz_v; bus.mask = mk_v;
            e = m_elig(rz_v, mk_v, rp_m);
            k = m_lowest(e);
            pulse_chk();
            total++;
            if (bus.irq !== (e != '0)) begin
                bad++;
                $display("FAIL rand_irq[%0d]: irq=%b want %b", it, bus.irq, (e != '0));
            end
            if (k >= 0) begin
                total++;
                if (bus.valid !== 1'b1 || bus.num !== IW'(k)) begin
                    bad++;
                    $display("FAIL rand_offer[%0d]: valid=%b num=%0d want 1/%0d", it, bus.valid, bus.num, k);
                end
                bus.rz = $urandom;
                pulse_ack();
                bitv = N'(1) << k;
                total++;
                if (bus.clr !== bitv || bus.rp !== (rp_m | bitv)) begin
                    bad++;
                    $display("FAIL rand_clear[%0d]: clr=%h rp=%h want %h/%h", it, bus.clr, bus.rp, bitv, rp_m | bitv);
                end
                rp_m = rp_m | bitv;
                bus.rz = '0;
                tick();
                total++;
                if (bus.busy !== 1'b0) begin
                    bad++;
                    $display("FAIL rand_idle[%0d]: busy=%b want 0", it, bus.busy);
                end
                $display("txn rand %0d rz=%h mask=%h num=%0d rp=%h", it, rz_v, mk_v, k, rp_m);
            end else begin
                total++;
                if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
                    bad++;
                    $display("FAIL rand_none[%0d]: valid=%b busy=%b want 0/0", it, bus.valid, bus.busy);
                end
                $display("txn rand %0d rz=%h mask=%h no offer rp=%h", it, rz_v, mk_v, rp_m);
            end
        end
        drain_rp();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_nesting();
        test_corner();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
